wb_gpio_irq: RTL

//  Parametrised Wishbone GPIO peripheral, successor to the 16-in/16-out wbgpio on the SoC bus.

---
 rtl/wb_gpio_irq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO peripheral with per-pin direction, input
// synchronisers, per-pin programmable debounce and rising/falling-edge IRQs.
//
// Ports:
//   wb_clk_i, wb_rstn_i        clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i  Wishbone slave request (byte address, [4:2] used)
//   wb_cyc_i/stb_i             Wishbone cycle / strobe
//   wb_dat_o/ack_o             read data (valid with ack), single-cycle ack
//   gpio_i                     asynchronous pad inputs
//   gpio_o/gpio_oe_o           pad output values / output enables
//   irq_o                      level interrupt, registered OR of IRQ_STATUS
//
// Register map (byte offsets): 00 DATA_IN RO, 04 DATA_OUT, 08 DIR,
// 0C IRQ_RISE, 10 IRQ_FALL, 14 IRQ_STATUS W1C, 18 DEBOUNCE, 1C OUT_TGL WO.

// Per-pin debounce lane: deb follows sync once it has differed for more
// than thr_i consecutive cycles.
module wb_gpio_irq_deb #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sync_i,
    input  logic [W-1:0] thr_i,
    output logic         deb_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         deb_q, deb_d;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_i != deb_q) begin
            // >= so a threshold lowered mid-count commits immediately and
            // the counter can never wrap.
            if (cnt_q >= thr_i) deb_d = sync_i;
            else                cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module wb_gpio_irq #(
    parameter int               NPINS       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEBOUNCE_W  = 16,
    parameter logic [NPINS-1:0] RESET_OUT   = '0,
    parameter logic [NPINS-1:0] RESET_DIR   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [NPINS-1:0] gpio_i,
    output logic [NPINS-1:0] gpio_o,
    output logic [NPINS-1:0] gpio_oe_o,
    output logic             irq_o
);
    localparam logic [2:0] A_DIN  = 3'd0, A_DOUT = 3'd1, A_DIR  = 3'd2, A_RISE = 3'd3,
                           A_FALL = 3'd4, A_STAT = 3'd5, A_DBN  = 3'd6, A_TGL  = 3'd7;

    logic                                 ack_q, irq_q;
    logic [31:0]                          dat_q, dat_d;
    logic [NPINS-1:0]                     out_q, out_d, dir_q, dir_d;
    logic [NPINS-1:0]                     rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NPINS-1:0]                     stat_q, stat_d;
    logic [DEBOUNCE_W-1:0]                dbn_q, dbn_d;
    logic [SYNC_STAGES-1:0][NPINS-1:0]    sync_q;
    logic [NPINS-1:0]                     deb, prev_q, rise, fall;

    // Accept a new request only when not already acking: a held strobe
    // therefore gets an ack every second cycle.
    logic        req, wr;
    logic [2:0]  rsel;
    logic [31:0] bmask, rd;
    logic [NPINS-1:0] pmask, wbits;

    assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr    = req & wb_we_i;
    assign rsel  = wb_adr_i[4:2];
    assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign pmask = bmask[NPINS-1:0];
    assign wbits = wb_dat_i[NPINS-1:0] & pmask;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, bmask};

    // Input path: synchroniser chain, then per-pin debounce lanes.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
    end

    for (genvar i = 0; i < NPINS; i++) begin : g_lane
        wb_gpio_irq_deb #(.W(DEBOUNCE_W)) u_deb (
            .clk_i  (wb_clk_i),
            .rst_ni (wb_rstn_i),
            .sync_i (sync_q[SYNC_STAGES-1][i]),
            .thr_i  (dbn_q),
            .deb_o  (deb[i])
        );
    end

    assign rise = deb & ~prev_q;
    assign fall = ~deb & prev_q;

    always_comb begin
        rd = '0;
        case (rsel)
            A_DIN:   rd[NPINS-1:0]      = deb;
            A_DOUT:  rd[NPINS-1:0]      = out_q;
            A_DIR:   rd[NPINS-1:0]      = dir_q;
            A_RISE:  rd[NPINS-1:0]      = rise_en_q;
            A_FALL:  rd[NPINS-1:0]      = fall_en_q;
            A_STAT:  rd[NPINS-1:0]      = stat_q;
            A_DBN:   rd[DEBOUNCE_W-1:0] = dbn_q;
            default: rd = '0;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        dbn_d     = dbn_q;
        dat_d     = (req & ~wb_we_i) ? rd : 32'h0;
        // New events OR'd in after the W1C mask, so a same-cycle set wins.
        stat_d    = stat_q | (rise & rise_en_q) | (fall & fall_en_q);
        if (wr) begin
            case (rsel)
                A_DOUT: out_d     = (out_q & ~pmask) | wbits;
                A_DIR:  dir_d     = (dir_q & ~pmask) | wbits;
                A_RISE: rise_en_d = (rise_en_q & ~pmask) | wbits;
                A_FALL: fall_en_d = (fall_en_q & ~pmask) | wbits;
                A_STAT: stat_d    = (stat_q & ~wbits) | (rise & rise_en_q) | (fall & fall_en_q);
                A_DBN:  dbn_d     = (dbn_q & ~bmask[DEBOUNCE_W-1:0])
                                  | (wb_dat_i[DEBOUNCE_W-1:0] & bmask[DEBOUNCE_W-1:0]);
                A_TGL:  out_d     = out_q ^ wbits;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            out_q     <= RESET_OUT;
            dir_q     <= RESET_DIR;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            dbn_q     <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= req;
            dat_q     <= dat_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            dbn_q     <= dbn_d;
            prev_q    <= deb;
            irq_q     <= |stat_q;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;
endmodule
